// File: rtl/arb_xfer_pkg.sv
// Shared types for the arbiter transfer controller.
// Burst FSM states and owner encoding.
package arb_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } xfer_state_t;

  typedef logic owner_t;

  localparam owner_t OWNER_0 = 1'b0;
  localparam owner_t OWNER_1 = 1'b1;

endpackage

// File: rtl/xfer_beat_cnt.sv
// Loadable down-counter holding the remaining beats-1 of a burst.
// Saturates at zero so a full-length burst never wraps.
module xfer_beat_cnt
  import arb_xfer_pkg::*;
#(
  parameter int LW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [LW-1:0] load_val,
  output logic          is_zero
);

  logic [LW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/arb_xfer_ctrl.sv
// Burst transfer stage behind the 2-requester arbiter.
// Optional stall abort is built when XFER_TIMEOUT_EN is defined.
module arb_xfer_ctrl
  import arb_xfer_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 4
`ifdef XFER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          gnt_0,
  input  logic          gnt_1,
  input  logic [DW-1:0] data_0,
  input  logic [DW-1:0] data_1,
  input  logic [LW-1:0] len_0,
  input  logic [LW-1:0] len_1,
  input  logic          bus_ready,
  output logic          bus_valid,
  output logic [DW-1:0] bus_data,
  output logic          bus_src,
  output logic          bus_last,
  output logic          done_0,
  output logic          done_1,
  output logic          busy,
  output logic          err
);

  xfer_state_t   state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          start;
  logic          beat;
  logic          cnt_zero;
  logic          timeout;
  logic [LW-1:0] load_len;

  assign start    = (state_q == IDLE) & (gnt_0 | gnt_1);
  assign beat     = (state_q == XFER) & bus_ready;
  assign load_len = gnt_0 ? len_0 : len_1;

  // gnt_0 takes priority when both grants arrive together
  assign owner_d  = start ? (gnt_0 ? OWNER_0 : OWNER_1) : owner_q;

  xfer_beat_cnt #(
    .LW(LW)
  ) u_beat_cnt (
    .clock   (clock),
    .reset   (reset),
    .load    (start),
    .dec     (beat),
    .load_val(load_len),
    .is_zero (cnt_zero)
  );

`ifdef XFER_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);

  logic [SW-1:0] stall_q, stall_d;
  logic          abort_q, abort_d;

  always_comb begin
    stall_d = '0;
    if ((state_q == XFER) && !bus_ready) begin
      stall_d = stall_q + 1'b1;
    end
  end

  assign timeout = (state_q == XFER) & ~bus_ready &
                   (stall_q == SW'(TIMEOUT - 1));
  assign abort_d = timeout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      stall_q <= stall_d;
      abort_q <= abort_d;
    end
  end

  assign err = (state_q == DONE) & abort_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = XFER;
      XFER: if ((beat && cnt_zero) || timeout) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWNER_0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign bus_valid = (state_q == XFER);
  assign bus_data  = bus_valid ? (owner_q ? data_1 : data_0) : '0;
  assign bus_src   = owner_q;
  assign bus_last  = bus_valid & cnt_zero;
  assign done_0    = (state_q == DONE) & (owner_q == OWNER_0);
  assign done_1    = (state_q == DONE) & (owner_q == OWNER_1);
  assign busy      = (state_q != IDLE);

endmodule
